// File: rtl/bp_common_pkg.sv
// rtl/bp_common_pkg.sv - shared types for the LCE request arbiter
package bp_common_pkg;

    localparam int lce_req_arb_ports_gp = 2;

    typedef enum logic {
        e_arb_src_icache = 1'b0,
        e_arb_src_dcache = 1'b1
    } bp_lce_req_arb_src_e;

endpackage

// File: rtl/bp_lce_req_arb_credit_cnt.sv
// rtl/bp_lce_req_arb_credit_cnt.sv - per-requester outstanding-request counter with empty/full flags
module bp_lce_req_arb_credit_cnt #(
    parameter int credits_p = 8
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic empty_o,
    output logic full_o
);

    localparam int credit_width_p = $clog2(credits_p + 1);
    localparam logic [credit_width_p-1:0] max_lp = credit_width_p'(credits_p);
    localparam logic [credit_width_p-1:0] one_lp = credit_width_p'(1);

    logic [credit_width_p-1:0] cnt_r;
    logic dec_ok;

    // A return with nothing outstanding is dropped so the count cannot wrap.
    assign dec_ok = dec_i & (cnt_r != '0);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_r <= '0;
        end else if (inc_i & ~dec_ok & (cnt_r != max_lp)) begin
            cnt_r <= cnt_r + one_lp;
        end else if (dec_ok & ~inc_i) begin
            cnt_r <= cnt_r - one_lp;
        end
    end

    assign empty_o = (cnt_r == '0);
    assign full_o  = (cnt_r == max_lp);

    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(dec_i && (cnt_r == '0)))
                else $warning("credit return with no outstanding request");
        end
    end

endmodule

// File: rtl/bp_lce_req_arbiter.sv
// rtl/bp_lce_req_arbiter.sv - round-robin I$/D$ LCE request merge with per-port credits; BP_LCE_REQ_ARB_PERF_EN adds grant counters
module bp_lce_req_arbiter
    import bp_common_pkg::*;
#(
    parameter int msg_width_p = 128,
    parameter int credits_p   = 8
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,
    input  logic [lce_req_arb_ports_gp*msg_width_p-1:0] req_i,
    input  logic [lce_req_arb_ports_gp-1:0]         req_v_i,
    output logic [lce_req_arb_ports_gp-1:0]         req_ready_and_o,
    input  logic [lce_req_arb_ports_gp-1:0]         credit_return_i,
    output logic [msg_width_p-1:0]                  lce_req_o,
    output logic                                    lce_req_v_o,
    input  logic                                    lce_req_ready_and_i,
    output logic                                    lce_req_src_o,
    output logic [lce_req_arb_ports_gp-1:0]         credits_empty_o,
    output logic [lce_req_arb_ports_gp-1:0]         credits_full_o,
    output logic [lce_req_arb_ports_gp*32-1:0]      grant_cnt_o
);

    logic                      slot_full;
    logic [msg_width_p-1:0]    slot_msg;
    bp_lce_req_arb_src_e       slot_src;
    bp_lce_req_arb_src_e       last_grant;

    logic [lce_req_arb_ports_gp-1:0] elig;
    logic [lce_req_arb_ports_gp-1:0] accept;
    logic                            slot_free;
    logic                            grant_v;
    bp_lce_req_arb_src_e             grant_src;

    assign elig      = req_v_i & ~credits_full_o;
    assign slot_free = ~slot_full | lce_req_ready_and_i;

    always_comb begin
        grant_src = e_arb_src_icache;
        if (&elig) begin
            grant_src = (last_grant == e_arb_src_icache) ? e_arb_src_dcache : e_arb_src_icache;
        end else if (elig[1]) begin
            grant_src = e_arb_src_dcache;
        end
    end

    // Ready is forced low while reset is held so no handshake can be seen mid-reset.
    assign grant_v = (|elig) & slot_free & reset_n_i;

    always_comb begin
        req_ready_and_o = '0;
        if (grant_v) begin
            req_ready_and_o[grant_src] = 1'b1;
        end
    end

    assign accept = req_v_i & req_ready_and_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            slot_full  <= 1'b0;
            slot_msg   <= '0;
            slot_src   <= e_arb_src_icache;
            last_grant <= e_arb_src_dcache;
        end else if (grant_v) begin
            slot_full  <= 1'b1;
            slot_msg   <= (grant_src == e_arb_src_dcache) ? req_i[2*msg_width_p-1:msg_width_p]
                                                           : req_i[msg_width_p-1:0];
            slot_src   <= grant_src;
            last_grant <= grant_src;
        end else if (lce_req_ready_and_i) begin
            slot_full  <= 1'b0;
        end
    end

    assign lce_req_v_o   = slot_full;
    assign lce_req_o     = slot_msg;
    assign lce_req_src_o = slot_src;

    for (genvar k = 0; k < lce_req_arb_ports_gp; k++) begin : g_credit
        bp_lce_req_arb_credit_cnt #(
            .credits_p(credits_p)
        ) u_cnt (
            .clk_i    (clk_i),
            .reset_n_i(reset_n_i),
            .inc_i    (accept[k]),
            .dec_i    (credit_return_i[k]),
            .empty_o  (credits_empty_o[k]),
            .full_o   (credits_full_o[k])
        );
    end

`ifdef BP_LCE_REQ_ARB_PERF_EN
    for (genvar k = 0; k < lce_req_arb_ports_gp; k++) begin : g_perf
        logic [31:0] gcnt;
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                gcnt <= '0;
            end else if (accept[k] && (gcnt != 32'hFFFF_FFFF)) begin
                gcnt <= gcnt + 32'd1;
            end
        end
        assign grant_cnt_o[k*32 +: 32] = gcnt;
    end
`else
    assign grant_cnt_o = '0;
`endif

endmodule
